// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scanner for a common-anode 7-segment display with tear-free frame-boundary updates.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading-zero digits above digit 0.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [3:0]            digit_out,
  output logic [DIGITS-1:0]     an,
  output logic                  blank,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                ready_q, ready_d;
  logic [3:0]          digit_q, digit_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                blank_q, blank_d;
  logic                tick_q, tick_d;
  logic                tc, frame_end, xfer;

  function automatic logic [3:0] nibble_at(input logic [4*DIGITS-1:0] v,
                                           input logic [IDX_W-1:0]    k);
    return v[4*k +: 4];
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Digit k>0 is blank when it and every nibble above it are zero.
  function automatic logic lead_zero(input logic [4*DIGITS-1:0] v,
                                     input logic [IDX_W-1:0]    k);
    logic z;
    z = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(k) && v[4*j +: 4] != 4'h0) z = 1'b0;
    end
    return z && (k != '0);
  endfunction
`endif

  always_comb begin
    tc        = (presc_q == PRE_LAST);
    frame_end = tc && (idx_q == IDX_LAST);
    xfer      = data_valid && ready_q;

    presc_d   = tc ? '0 : presc_q + PRE_W'(1);
    idx_d     = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    // ready_q == !pending_q, so a transfer and a commit never coincide;
    // a transfer on the boundary cycle therefore waits a full frame.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (xfer) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
    ready_d   = !pending_d;

    digit_d   = nibble_at(active_d, idx_d);
    an_d      = ~(AN_ONE << idx_d);
    blank_d   = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (lead_zero(active_d, idx_d)) begin
      blank_d = 1'b1;
      an_d    = '1;
    end
`endif
    tick_d    = frame_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      digit_q   <= '0;
      an_q      <= '1;
      blank_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      blank_q   <= blank_d;
      tick_q    <= tick_d;
    end
  end

  assign data_ready = ready_q;
  assign digit_out  = digit_q;
  assign an         = an_q;
  assign blank      = blank_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4): stimulus queues the value
// expected in each upcoming frame, a monitor checks every slot of every frame it is handed.
module tb_seg7_scan_driver;
  localparam int DIG  = 4;
  localparam int RDIV = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        blank;
  logic        frame_tick;

  int n_cmp  = 0;
  int n_fail = 0;
  logic        mon_en = 1'b0;
  logic [15:0] exp_q[$];

  seg7_scan_driver #(.DIGITS(DIG), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .digit_out(digit_out), .an(an), .blank(blank),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_blank(input logic [15:0] v, input int k);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    return (v >> (4 * k)) == 16'h0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_tick timeout: got none in 40 cycles, expected one");
    end
  endtask

  task automatic chk_reset_state();
    chk("reset an", 32'(an), 32'hF);
    chk("reset digit_out", 32'(digit_out), 32'h0);
    chk("reset blank", 32'(blank), 32'h0);
    chk("reset frame_tick", 32'(frame_tick), 32'h0);
    chk("reset data_ready", 32'(data_ready), 32'h1);
  endtask

  // Monitor: a frame begins at a frame_tick; each slot is checked over all its cycles.
  initial begin : monitor
    logic [15:0] ev;
    logic [3:0]  ean;
    logic        eb, bad, aborted, etk;
    forever begin
      @(negedge clk);
      if (mon_en && frame_tick && exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        aborted = 1'b0;
        for (int k = 0; k < DIG; k++) begin
          bad = 1'b0;
          eb  = exp_blank(ev, k);
          ean = eb ? 4'hF : ~(4'b0001 << k);
          for (int c = 0; c < RDIV; c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk);
            if (!mon_en) begin
              aborted = 1'b1;
              break;
            end
            etk = (k == 0 && c == 0);
            if (!bad && (an !== ean || digit_out !== ev[4*k +: 4] ||
                         blank !== eb || frame_tick !== etk)) begin
              bad = 1'b1;
              $display("FAIL frame %h slot %0d cyc %0d: got an=%b d=%h bl=%b ft=%b, expected an=%b d=%h bl=%b ft=%b",
                       ev, k, c, an, digit_out, blank, frame_tick, ean, ev[4*k +: 4], eb, etk);
            end
          end
          if (aborted) break;
          n_cmp++;
          if (bad) n_fail++;
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; data_valid = 1'b0; data_in = 16'h0;
    cyc(3);
    chk_reset_state();
    rst_n = 1'b1;
    cyc(1);
    chk("first an", 32'(an), 32'hE);
    chk("first digit_out", 32'(digit_out), 32'h0);
    exp_q.push_back(16'h0000);
    mon_en = 1'b1;

    // Idle frames show 0.
    wait_tick();
    chk("idle ready", 32'(data_ready), 32'h1);
    exp_q.push_back(16'h0000);

    // Mid-frame load: old value stays for the rest of this frame.
    wait_tick();
    exp_q.push_back(16'h1A3F);
    cyc(5);
    data_in = 16'h1A3F; data_valid = 1'b1;
    cyc(1);
    chk("ready after load", 32'(data_ready), 32'h0);
    data_in = 16'h5A5A;
    cyc(3);
    data_valid = 1'b0;

    // Held valid: 0x1111 taken, 0x2222 waits until ready returns.
    wait_tick();
    chk("ready after commit", 32'(data_ready), 32'h1);
    exp_q.push_back(16'h1111);
    cyc(2);
    data_in = 16'h1111; data_valid = 1'b1;
    cyc(1);
    chk("ready while pending", 32'(data_ready), 32'h0);
    data_in = 16'h2222;
    wait_tick();
    chk("ready back for 2222", 32'(data_ready), 32'h1);
    exp_q.push_back(16'h2222);
    cyc(1);
    data_valid = 1'b0;
    chk("ready after 2222", 32'(data_ready), 32'h0);

    // Transfer on the exact frame-boundary cycle.
    wait_tick();
    chk("ready before beef", 32'(data_ready), 32'h1);
    exp_q.push_back(16'h2222);
    cyc(15);
    chk("ready at boundary", 32'(data_ready), 32'h1);
    data_in = 16'hBEEF; data_valid = 1'b1;
    wait_tick();
    data_valid = 1'b0;
    chk("ready after boundary xfer", 32'(data_ready), 32'h0);
    exp_q.push_back(16'hBEEF);
    wait_tick();
    chk("ready after beef commit", 32'(data_ready), 32'h1);
    exp_q.push_back(16'hBEEF);

    // Reset during digit 2 with a pending value.
    wait_tick();
    cyc(1);
    data_in = 16'h7777; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    chk("ready pending 7777", 32'(data_ready), 32'h0);
    cyc(7);
    mon_en = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    cyc(1);
    chk_reset_state();
    rst_n = 1'b1;
    cyc(1);
    chk("restart an", 32'(an), 32'hE);
    chk("restart digit_out", 32'(digit_out), 32'h0);
    exp_q.push_back(16'h0000);
    mon_en = 1'b1;
    wait_tick();
    chk("ready after reset", 32'(data_ready), 32'h1);
    exp_q.push_back(16'h0000);

    // Leading-zero values.
    wait_tick();
    exp_q.push_back(16'h0030);
    cyc(3);
    data_in = 16'h0030; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    wait_tick();
    exp_q.push_back(16'h0000);
    cyc(3);
    data_in = 16'h0000; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    wait_tick();
    wait_tick();
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
- Sits directly upstream of the hex-to-7-segment decoder.
- Latches a packed multi-nibble value via a valid/ready handshake, then cycles through the digits at a programmable refresh rate.
- Each cycle it presents the selected nibble to the decoder and drives the active-low anode enables.

Parameters:
DIGITS, 4, number of display digits (2..8)
REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active low
data_in  input  4*DIGITS  packed hex value; nibble k = digit k, digit 0 = least significant
data_valid  input  1  data_in valid this cycle
data_ready  output  1  block can accept a new value
digit_out  output  4  nibble of the currently lit digit, to decoder input
an  output  DIGITS  anode enables, active low, one-hot-low when lit
blank  output  1  1 = decoder output must be suppressed for the current digit
frame_tick  output  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- All outputs are registered.
- Reset, sampled at a clk edge with rst_n=0:
  - prescaler=0, idx=0, active=0, shadow=0, pending=0
  - data_ready=1, digit_out=0, an=all ones, blank=0, frame_tick=0
- First edge with rst_n=1: an = ~(1<<0), digit_out = active[3:0].
- Reset mid-frame aborts the scan immediately; any pending value is discarded.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - Terminal count (TC) = prescaler==REFRESH_DIV-1.
  - At TC, idx advances; DIGITS-1 wraps to 0.
  - Each digit is therefore lit for exactly REFRESH_DIV cycles.
- Outputs per cycle:
  - an = ~(1<<idx_next), digit_out = active_next[4*idx_next +: 4].
  - The anode and the nibble change on the same edge; there is never a cycle with an anode lit and a stale nibble.
- Handshake:
  - Transfer occurs when data_valid && data_ready.
  - On transfer, shadow<=data_in and pending<=1; data_ready drops the next cycle.
  - data_ready = !pending (registered).
  - data_in is ignored while data_ready=0.
  - data_valid held high with data_ready=0 is legal; no loss, no error.
- Commit (tear-free update):
  - Frame boundary = TC with idx==DIGITS-1.
  - At a frame boundary with pending=1: active<=shadow, pending<=0, data_ready returns to 1 the following cycle.
  - Digit 0 of the next frame already shows the new value.
- Simultaneous transfer and frame boundary:
  - The value is captured into shadow only.
  - It is committed at the next frame boundary, never the same one.
- frame_tick:
  - Asserted for 1 cycle, registered, on the cycle after each frame boundary.
  - Aligned with an switching to digit 0.
- blank is 0 in the base build.

Optional Feature:
Macro: SEG7_LEADING_ZERO_BLANK_EN
- Defined:
  - A digit k>0 is blanked when it and every higher nibble of active are zero: blank=1 and that digit's an bit stays 1 (unlit) for its slot.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Slot timing is unchanged; blanked slots still consume REFRESH_DIV cycles.
- Undefined:
  - blank tied to 0.
  - Every digit is lit in turn.

Test Plan (DIGITS=4, REFRESH_DIV=4):
- Reset then idle -> an sequence 1110,1101,1011,0111, each held 4 cycles; digit_out=0; frame_tick pulses every 16 cycles; data_ready=1.
- Load 0x1A3F mid-frame (data_valid 1 cycle) -> data_ready low next cycle; old value kept until the frame ends; next frame digit_out=F,3,A,1; data_ready high again.
- Hold data_valid with 0x1111 then 0x2222 while pending -> only 0x1111 is displayed; 0x2222 is accepted after data_ready returns and is shown one frame later.
- Transfer on the exact frame-boundary cycle with 0xBEEF -> not shown in the immediately following frame; shown in the frame after.
- Assert rst_n=0 for 1 cycle during digit 2 with a pending value -> an=1111, pending cleared, active=0; scan restarts at digit 0.
- With SEG7_LEADING_ZERO_BLANK_EN, load 0x0030 -> digits 3 and 2 blank=1 with an bit high; digit 1 shows 3, digit 0 shows 0; load 0x0000 -> only digit 0 lit, showing 0.
